// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter giving N requesters turns on the single avalon_bus data port; optional BUSY timeout under ARB_TIMEOUT_EN.
// Latency: grant registered 1 cycle after request; bus signals and ReqDone combinational from the granted requester while BUSY.
// Backpressure: requests are held levels; losers simply stay asserted until served; one transaction in flight.
module data_bus_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N-1:0]    ReqRead,
  input  logic [N-1:0]    ReqWrite,
  input  logic [N*16-1:0] ReqAddr,
  input  logic [N*16-1:0] ReqWdata,
  output logic [15:0]     ReqRdata,
  output logic [N-1:0]    ReqDone,
  output logic [N-1:0]    ReqErr,
  output logic [N-1:0]    Grant,
  output logic            ReadData,
  output logic            WriteData,
  output logic [15:0]     DataAddr,
  output logic [15:0]     BusIn,
  input  logic [15:0]     BusOut,
  input  logic            DataDone
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  last_q, last_d;
  logic [N-1:0]   req_any;
  logic           found;
  logic [IW-1:0]  win;
  logic           busy, g_rd, g_wr, xfer_done, tmo;
  logic [15:0]    addr_a  [N];
  logic [15:0]    wdata_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign addr_a[i]  = ReqAddr[16*i +: 16];
    assign wdata_a[i] = ReqWdata[16*i +: 16];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // last_q doubles as the granted index while BUSY
  assign busy      = (state_q == BUSY);
  assign g_rd      = ReqRead[last_q];
  assign g_wr      = ReqWrite[last_q];
  assign ReadData  = busy & g_rd & ~g_wr;
  assign WriteData = busy & g_wr;
  assign DataAddr  = busy ? addr_a[last_q]  : 16'h0000;
  assign BusIn     = busy ? wdata_a[last_q] : 16'h0000;
  assign xfer_done = busy & DataDone & (ReadData | WriteData);
  assign Grant     = grant_q;
  assign req_any   = ReqRead | ReqWrite;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_any[wrap_inc(last_q, k)]) begin
        found = 1'b1;
        win   = wrap_inc(last_q, k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)          cnt_q <= '0;
    else if (!busy)     cnt_q <= '0;
    else if (!DataDone) cnt_q <= cnt_q + CW'(1);
  end

  assign tmo = busy & (cnt_q == CW'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    ReqDone  = '0;
    ReqErr   = '0;
    ReqRdata = 16'h0000;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          last_d       = win;
        end
      end
      BUSY: begin
        // completion beats a coincident timeout; a dropped request aborts silently
        if (xfer_done) begin
          ReqDone[last_q] = 1'b1;
          ReqRdata        = ReadData ? BusOut : 16'h0000;
          state_d         = IDLE;
          grant_d         = '0;
        end else if (!(g_rd | g_wr)) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (tmo) begin
          ReqDone[last_q] = 1'b1;
          ReqErr[last_q]  = 1'b1;
          state_d         = IDLE;
          grant_d         = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
